// File: rtl/ariane_pkg.sv
// Shared core types: functional-unit and ALU opcodes, the exception record and the
// scoreboard entry passed between decode, issue and commit.
package ariane_pkg;

    localparam int NR_SB_ENTRIES = 8;
    localparam int TRANS_ID_BITS = 5;

    typedef enum logic [3:0] {
        NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR
    } fu_t;

    typedef enum logic [4:0] {
        ADD, SUB, XORL, ORL, ANDL, SRA, SRL, SLL, SLTS, SLTU, EQ, NE, LTS, GES
    } alu_op;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception;

    // valid marks a written-back result, not a present entry
    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        alu_op                    op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        logic                     use_imm;
        exception                 ex;
    } scoreboard_entry;

endpackage

// File: rtl/scoreboard_rs_lookup.sv
// Finds the youngest in-flight entry whose rd matches rs; reports busy and, when
// SCOREBOARD_FWD_EN is defined, whether that entry's result can be forwarded.
module sb_rs_lookup
    import ariane_pkg::*;
#(
    parameter int NR_ENTRIES = NR_SB_ENTRIES
) (
    input  logic [NR_ENTRIES-1:0][4:0]  rd,
    input  logic [NR_ENTRIES-1:0]       written,
    input  logic [NR_ENTRIES-1:0][63:0] result,
    input  logic [$clog2(NR_ENTRIES)-1:0] commit_ptr,
    input  logic [$clog2(NR_ENTRIES):0]   count,
    input  logic [4:0]                  rs,
    output logic                        busy,
    output logic                        fwd,
    output logic [63:0]                 value
);

    localparam int PTR_W = $clog2(NR_ENTRIES);

    logic             hit;
    logic [PTR_W-1:0] hit_idx;
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match wins
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        idx     = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            idx = commit_ptr + PTR_W'(i);
            if ((PTR_W+1)'(i) < count && rs != 5'd0 && rd[idx] == rs) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

    assign busy = hit;

`ifdef SCOREBOARD_FWD_EN
    assign fwd   = hit && written[hit_idx];
    assign value = hit ? result[hit_idx] : 64'd0;
`else
    logic unused_fwd_src;
    assign unused_fwd_src = ^{written, result, hit_idx};
    assign fwd   = 1'b0;
    assign value = 64'd0;
`endif

endmodule

// File: rtl/scoreboard.sv
// In-order circular scoreboard between decode and EX/commit with rs busy lookup.
// Optional result forwarding on the rs ports is enabled by defining SCOREBOARD_FWD_EN.
module scoreboard
    import ariane_pkg::*;
#(
    parameter int NR_ENTRIES = NR_SB_ENTRIES
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    output logic                     full_o,
    input  scoreboard_entry          decoded_instr_i,
    input  logic                     decoded_instr_valid_i,
    output logic                     decoded_instr_ack_o,
    output scoreboard_entry          issue_instr_o,
    output logic                     issue_instr_valid_o,
    input  logic                     issue_ack_i,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    output logic                     rs1_busy_o,
    output logic                     rs2_busy_o,
    output logic                     rs1_fwd_o,
    output logic                     rs2_fwd_o,
    output logic [63:0]              rs1_o,
    output logic [63:0]              rs2_o,
    input  logic                     wb_valid_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    input  logic [63:0]              wdata_i,
    input  exception                 ex_i,
    output scoreboard_entry          commit_instr_o,
    output logic                     commit_valid_o,
    input  logic                     commit_ack_i
);

    localparam int PTR_W = $clog2(NR_ENTRIES);

    scoreboard_entry  mem [NR_ENTRIES];
    logic [PTR_W-1:0] write_ptr, issue_ptr, commit_ptr;
    logic [PTR_W:0]   count, unissued;

    logic             push, issue, commit, wb_hit;
    logic [PTR_W-1:0] wb_idx, wb_age;
    scoreboard_entry  new_entry;

    assign full_o              = count == (PTR_W+1)'(NR_ENTRIES);
    assign push                = decoded_instr_valid_i && !full_o && !flush_i;
    assign decoded_instr_ack_o = push;

    assign issue_instr_valid_o = unissued != '0;
    assign issue_instr_o       = mem[issue_ptr];
    assign issue               = issue_ack_i && issue_instr_valid_o;

    assign commit_valid_o      = count != '0 && mem[commit_ptr].valid;
    assign commit_instr_o      = mem[commit_ptr];
    assign commit              = commit_ack_i && commit_valid_o;

    // A writeback only lands if its index lies inside the commit..write window
    assign wb_idx = trans_id_i[PTR_W-1:0];
    assign wb_age = wb_idx - commit_ptr;
    assign wb_hit = wb_valid_i && ((trans_id_i >> PTR_W) == '0) && ({1'b0, wb_age} < count);

    always_comb begin
        new_entry          = decoded_instr_i;
        new_entry.trans_id = TRANS_ID_BITS'(write_ptr);
        new_entry.valid    = 1'b0;
        new_entry.result   = 64'd0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            write_ptr  <= '0;
            issue_ptr  <= '0;
            commit_ptr <= '0;
            count      <= '0;
            unissued   <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[write_ptr] <= new_entry;
                write_ptr      <= write_ptr + PTR_W'(1);
            end
            if (wb_hit) begin
                mem[wb_idx].result <= wdata_i;
                mem[wb_idx].valid  <= 1'b1;
                if (ex_i.valid) begin
                    mem[wb_idx].ex <= ex_i;
                end
            end
            // Last so a retired slot never keeps a stale written-back flag
            if (commit) begin
                mem[commit_ptr].valid <= 1'b0;
                commit_ptr            <= commit_ptr + PTR_W'(1);
            end
            if (issue) begin
                issue_ptr <= issue_ptr + PTR_W'(1);
            end
            count    <= count + (PTR_W+1)'(push) - (PTR_W+1)'(commit);
            unissued <= unissued + (PTR_W+1)'(push) - (PTR_W+1)'(issue);
        end
    end

    logic [NR_ENTRIES-1:0][4:0]  sb_rd;
    logic [NR_ENTRIES-1:0]       sb_written;
    logic [NR_ENTRIES-1:0][63:0] sb_result;

    always_comb begin
        sb_rd      = '0;
        sb_written = '0;
        sb_result  = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            sb_rd[i]      = mem[i].rd;
            sb_written[i] = mem[i].valid;
            sb_result[i]  = mem[i].result;
        end
    end

    sb_rs_lookup #(.NR_ENTRIES(NR_ENTRIES)) u_rs1_lookup (
        .rd         (sb_rd),
        .written    (sb_written),
        .result     (sb_result),
        .commit_ptr (commit_ptr),
        .count      (count),
        .rs         (rs1_i),
        .busy       (rs1_busy_o),
        .fwd        (rs1_fwd_o),
        .value      (rs1_o)
    );

    sb_rs_lookup #(.NR_ENTRIES(NR_ENTRIES)) u_rs2_lookup (
        .rd         (sb_rd),
        .written    (sb_written),
        .result     (sb_result),
        .commit_ptr (commit_ptr),
        .count      (count),
        .rs         (rs2_i),
        .busy       (rs2_busy_o),
        .fwd        (rs2_fwd_o),
        .value      (rs2_o)
    );

endmodule

// File: tb/tb_scoreboard.sv
// Bench for scoreboard: queue-based reference model, lookup vector table and
// directed multi-cycle sequences; honours SCOREBOARD_FWD_EN when defined.
`timescale 1ns/1ps
module tb_scoreboard;
    import ariane_pkg::*;

    localparam int N = NR_SB_ENTRIES;
`ifdef SCOREBOARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clk_i, rst_ni, flush_i, full_o;
    scoreboard_entry decoded_instr_i, issue_instr_o, commit_instr_o;
    logic            decoded_instr_valid_i, decoded_instr_ack_o;
    logic            issue_instr_valid_o, issue_ack_i;
    logic [4:0]      rs1_i, rs2_i;
    logic            rs1_busy_o, rs2_busy_o, rs1_fwd_o, rs2_fwd_o;
    logic [63:0]     rs1_o, rs2_o;
    logic            wb_valid_i;
    logic [4:0]      trans_id_i;
    logic [63:0]     wdata_i;
    exception        ex_i;
    logic            commit_valid_o, commit_ack_i;

    scoreboard #(.NR_ENTRIES(N)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .full_o(full_o),
        .decoded_instr_i(decoded_instr_i), .decoded_instr_valid_i(decoded_instr_valid_i),
        .decoded_instr_ack_o(decoded_instr_ack_o),
        .issue_instr_o(issue_instr_o), .issue_instr_valid_o(issue_instr_valid_o),
        .issue_ack_i(issue_ack_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
        .rs1_fwd_o(rs1_fwd_o), .rs2_fwd_o(rs2_fwd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .wb_valid_i(wb_valid_i), .trans_id_i(trans_id_i), .wdata_i(wdata_i), .ex_i(ex_i),
        .commit_instr_o(commit_instr_o), .commit_valid_o(commit_valid_o),
        .commit_ack_i(commit_ack_i)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: in-order queue ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [4:0]  tid;
        bit          wb;
        logic [63:0] result;
        bit          exv;
        logic [63:0] cause;
        logic [63:0] pc;
    } m_ent_t;

    typedef struct {
        logic [4:0]  tid;
        logic [63:0] pc;
    } obs_t;

    m_ent_t      m_q[$];
    int          m_issued   = 0;
    int          m_next_tid = 0;
    logic [63:0] pc_ctr     = 64'h1000;
    obs_t        obs_q[$];

    // Drive variables
    bit          d_rst, d_flush, d_push, d_issue, d_wb, d_exv, d_commit;
    logic [4:0]  d_rd, d_tid, d_rs1, d_rs2;
    logic [63:0] d_wdata, d_cause;

    task automatic clear_drv();
        d_rst = 0; d_flush = 0; d_push = 0; d_issue = 0; d_wb = 0; d_exv = 0; d_commit = 0;
        d_rd = 0; d_tid = 0; d_rs1 = 0; d_rs2 = 0; d_wdata = 0; d_cause = 0;
    endtask

    task automatic apply_inputs();
        rst_ni                   = !d_rst;
        flush_i                  = d_flush;
        decoded_instr_i          = '0;
        decoded_instr_i.pc       = pc_ctr;
        decoded_instr_i.rd       = d_rd;
        decoded_instr_i.fu       = ALU;
        decoded_instr_i.trans_id = 5'h1f;
        decoded_instr_i.valid    = 1'b1;
        decoded_instr_i.result   = 64'hBAD0;
        decoded_instr_valid_i    = d_push;
        issue_ack_i              = d_issue;
        rs1_i                    = d_rs1;
        rs2_i                    = d_rs2;
        wb_valid_i               = d_wb;
        trans_id_i               = d_tid;
        wdata_i                  = d_wdata;
        ex_i                     = '0;
        ex_i.valid               = d_exv;
        ex_i.cause               = d_cause;
        commit_ack_i             = d_commit;
    endtask

    function automatic void m_lookup(input logic [4:0] rs, output logic busy,
                                     output logic fwd, output logic [63:0] val);
        busy = 0; fwd = 0; val = 0;
        if (rs != 0) begin
            foreach (m_q[i]) begin
                if (m_q[i].rd == rs) begin
                    busy = 1;
                    fwd  = FWD && m_q[i].wb;
                    val  = FWD ? m_q[i].result : 64'd0;
                end
            end
        end
    endfunction

    task automatic model_compare();
        int          sz;
        bit          e_full, e_iv, e_cv;
        logic        b, f;
        logic [63:0] v;
        sz     = m_q.size();
        e_full = (sz == N);
        e_iv   = (m_issued < sz);
        e_cv   = (sz != 0) && m_q[0].wb;
        chk("full", full_o, e_full);
        chk("ack", decoded_instr_ack_o, d_push && !e_full && !d_flush);
        chk("issue_valid", issue_instr_valid_o, e_iv);
        if (e_iv) begin
            chk("issue_tid", issue_instr_o.trans_id, m_q[m_issued].tid);
            chk("issue_pc", issue_instr_o.pc, m_q[m_issued].pc);
            chk("issue_rd", issue_instr_o.rd, m_q[m_issued].rd);
            chk("issue_wbflag", issue_instr_o.valid, m_q[m_issued].wb);
        end
        chk("commit_valid", commit_valid_o, e_cv);
        if (e_cv) begin
            chk("commit_tid", commit_instr_o.trans_id, m_q[0].tid);
            chk("commit_pc", commit_instr_o.pc, m_q[0].pc);
            chk("commit_result", commit_instr_o.result, m_q[0].result);
            chk("commit_exv", commit_instr_o.ex.valid, m_q[0].exv);
            chk("commit_cause", commit_instr_o.ex.cause, m_q[0].cause);
        end
        m_lookup(d_rs1, b, f, v);
        chk("rs1_busy", rs1_busy_o, b);
        chk("rs1_fwd", rs1_fwd_o, f);
        chk("rs1_val", rs1_o, v);
        m_lookup(d_rs2, b, f, v);
        chk("rs2_busy", rs2_busy_o, b);
        chk("rs2_fwd", rs2_fwd_o, f);
        chk("rs2_val", rs2_o, v);
    endtask

    task automatic model_step();
        int sz;
        bit cv, iv;
        sz = m_q.size();
        if (d_rst || d_flush) begin
            m_q.delete();
            m_issued   = 0;
            m_next_tid = 0;
        end else begin
            cv = (sz != 0) && m_q[0].wb;
            iv = (m_issued < sz);
            if (d_wb) begin
                foreach (m_q[i]) begin
                    if (m_q[i].tid == d_tid) begin
                        m_q[i].wb     = 1;
                        m_q[i].result = d_wdata;
                        if (d_exv) begin
                            m_q[i].exv   = 1;
                            m_q[i].cause = d_cause;
                        end
                    end
                end
            end
            if (d_commit && cv) begin
                void'(m_q.pop_front());
                m_issued--;
            end
            if (d_issue && iv) m_issued++;
            if (d_push && sz < N) begin
                m_q.push_back('{rd: d_rd, tid: 5'(m_next_tid), wb: 0, result: 0,
                                exv: 0, cause: 0, pc: pc_ctr});
                m_next_tid = (m_next_tid + 1) % N;
                pc_ctr     = pc_ctr + 4;
            end
        end
    endtask

    // One clock: apply, check against model mid-cycle, clock, update model, go idle
    task automatic do_cycle();
        apply_inputs();
        #2;
        if (chk_en) model_compare();
        if (chk_en && d_commit && commit_valid_o)
            obs_q.push_back('{tid: commit_instr_o.trans_id, pc: commit_instr_o.pc});
        @(posedge clk_i);
        model_step();
        #1;
        clear_drv();
        apply_inputs();
        #1;
    endtask

    task automatic realign();
        @(posedge clk_i);
        #2;
    endtask

    task automatic do_flush();
        d_flush = 1;
        do_cycle();
    endtask

    function automatic int first_unwb();
        for (int i = 0; i < m_issued; i++) begin
            if (!m_q[i].wb) return i;
        end
        return -1;
    endfunction

    // ---------------- lookup vector table ----------------
    typedef struct {
        logic [4:0]  rs;
        bit          busy;
        bit          fwd;
        logic [63:0] val;
    } vec_t;

    vec_t       vecs[6];
    logic [4:0] t3_rd[5];
    logic [4:0] exp_q[$];

    initial begin
        int  k;
        int  j;
        bit  seq_ok;
        bit  wrap_seen;
        vecs[0] = '{rs: 5'd3,  busy: 1, fwd: 1, val: 64'h22};
        vecs[1] = '{rs: 5'd0,  busy: 0, fwd: 0, val: 64'h0};
        vecs[2] = '{rs: 5'd7,  busy: 1, fwd: 1, val: 64'h77};
        vecs[3] = '{rs: 5'd9,  busy: 1, fwd: 0, val: 64'h0};
        vecs[4] = '{rs: 5'd4,  busy: 0, fwd: 0, val: 64'h0};
        vecs[5] = '{rs: 5'd31, busy: 0, fwd: 0, val: 64'h0};
        t3_rd = '{5'd3, 5'd3, 5'd7, 5'd9, 5'd0};

        // Reset
        clear_drv();
        apply_inputs();
        repeat (2) begin
            d_rst = 1;
            do_cycle();
        end
        chk_en = 1;
        chk("reset_full", full_o, 0);
        chk("reset_issue_valid", issue_instr_valid_o, 0);
        chk("reset_commit_valid", commit_valid_o, 0);
        chk("reset_ack", decoded_instr_ack_o, 0);
        chk("reset_issue_instr_zero", issue_instr_o == '0, 1);
        chk("reset_commit_instr_zero", commit_instr_o == '0, 1);
        chk("reset_rs1_busy", rs1_busy_o, 0);
        chk("reset_rs1_o", rs1_o, 0);

        // 1: fill without issue, ninth push refused, trans_ids 0..7 in order
        do_flush();
        for (int i = 0; i < N; i++) begin
            d_push = 1; d_rd = 5'(i + 1);
            do_cycle();
        end
        chk("t1_full", full_o, 1);
        d_push = 1; d_rd = 5'd9;
        apply_inputs();
        #1;
        chk("t1_ninth_ack", decoded_instr_ack_o, 0);
        do_cycle();
        for (int i = 0; i < N; i++) begin
            chk("t1_tid", issue_instr_o.trans_id, i);
            chk("t1_rd", issue_instr_o.rd, i + 1);
            d_issue = 1;
            do_cycle();
        end
        chk("t1_issue_drained", issue_instr_valid_o, 0);

        // 2: single instruction round trip
        do_flush();
        d_push = 1; d_rd = 5'd5;
        do_cycle();
        d_issue = 1;
        do_cycle();
        d_wb = 1; d_tid = 0; d_wdata = 64'hDEAD;
        do_cycle();
        chk("t2_commit_valid", commit_valid_o, 1);
        chk("t2_commit_result", commit_instr_o.result, 64'hDEAD);
        chk("t2_commit_tid", commit_instr_o.trans_id, 0);
        d_commit = 1;
        do_cycle();
        chk("t2_commit_valid_after", commit_valid_o, 0);
        chk("t2_issue_valid_after", issue_instr_valid_o, 0);
        chk("t2_full_after", full_o, 0);
        d_rs1 = 5'd5;
        apply_inputs();
        #1;
        chk("t2_rd5_free", rs1_busy_o, 0);

        // 3: youngest-match lookup, driven from the vector table
        do_flush();
        for (int i = 0; i < 5; i++) begin
            d_push = 1; d_rd = t3_rd[i]; d_issue = 1;
            do_cycle();
        end
        d_wb = 1; d_tid = 0; d_wdata = 64'h11;
        do_cycle();
        d_wb = 1; d_tid = 1; d_wdata = 64'h22;
        do_cycle();
        d_wb = 1; d_tid = 2; d_wdata = 64'h77;
        do_cycle();
        for (int i = 0; i < 6; i++) begin
            j = (i + 1) % 6;
            d_rs1 = vecs[i].rs;
            d_rs2 = vecs[j].rs;
            apply_inputs();
            #1;
            chk("t3_rs1_busy", rs1_busy_o, vecs[i].busy);
            chk("t3_rs1_fwd", rs1_fwd_o, FWD && vecs[i].fwd);
            chk("t3_rs1_val", rs1_o, FWD ? vecs[i].val : 64'd0);
            chk("t3_rs2_busy", rs2_busy_o, vecs[j].busy);
            chk("t3_rs2_fwd", rs2_fwd_o, FWD && vecs[j].fwd);
            chk("t3_rs2_val", rs2_o, FWD ? vecs[j].val : 64'd0);
            realign();
        end

        // 4: out-of-order writeback, in-order commit, exception capture
        do_flush();
        for (int i = 0; i < 4; i++) begin
            d_push = (i < 3); d_rd = 5'(10 + i); d_issue = 1;
            do_cycle();
        end
        obs_q.delete();
        exp_q = '{5'd0, 5'd1, 5'd2};
        d_wb = 1; d_tid = 2; d_wdata = 64'h202; d_commit = 1;
        do_cycle();
        d_wb = 1; d_tid = 0; d_wdata = 64'h200; d_commit = 1;
        do_cycle();
        d_wb = 1; d_tid = 1; d_wdata = 64'h201; d_commit = 1;
        do_cycle();
        for (int i = 0; i < 4; i++) begin
            d_commit = 1;
            do_cycle();
        end
        chk("t4_commit_count", obs_q.size(), exp_q.size());
        for (k = 0; k < exp_q.size(); k++) begin
            if (k < obs_q.size()) chk("t4_commit_order", obs_q[k].tid, exp_q[k]);
        end
        d_push = 1; d_rd = 5'd4;
        do_cycle();
        d_issue = 1;
        do_cycle();
        d_wb = 1; d_tid = 3; d_wdata = 64'h1; d_exv = 1; d_cause = 64'd2;
        do_cycle();
        chk("t4_ex_commit_valid", commit_valid_o, 1);
        chk("t4_ex_cause", commit_instr_o.ex.cause, 2);
        chk("t4_ex_valid", commit_instr_o.ex.valid, 1);
        d_commit = 1;
        do_cycle();

        // 5: steady full-depth traffic, trans_id wrap, no loss or duplication
        do_flush();
        for (int i = 0; i < N; i++) begin
            d_push = 1; d_rd = 5'($urandom_range(1, 7)); d_issue = 1;
            do_cycle();
        end
        obs_q.delete();
        for (int i = 0; i < 20; i++) begin
            d_push = 1; d_rd = 5'($urandom_range(1, 7)); d_issue = 1; d_commit = 1;
            k = first_unwb();
            if (k >= 0) begin
                d_wb = 1; d_tid = m_q[k].tid; d_wdata = {$urandom, $urandom};
            end
            do_cycle();
        end
        seq_ok = 1;
        wrap_seen = 0;
        for (k = 1; k < obs_q.size(); k++) begin
            if (obs_q[k].pc != obs_q[k-1].pc + 4) seq_ok = 0;
            if (obs_q[k].tid != 5'((obs_q[k-1].tid + 1) % N)) seq_ok = 0;
            if (obs_q[k-1].tid == 5'd7 && obs_q[k].tid == 5'd0) wrap_seen = 1;
        end
        chk("t5_commit_count", obs_q.size() >= 16, 1);
        chk("t5_no_loss_dup", seq_ok, 1);
        chk("t5_tid_wrap", wrap_seen, 1);

        // 6: flush with concurrent push, then reset mid-stream
        do_flush();
        for (int i = 0; i < 5; i++) begin
            d_push = 1; d_rd = 5'(i + 1); d_issue = 1;
            do_cycle();
        end
        d_wb = 1; d_tid = 0; d_wdata = 64'h55;
        do_cycle();
        d_flush = 1; d_push = 1; d_rd = 5'd2;
        apply_inputs();
        #1;
        chk("t6_flush_ack", decoded_instr_ack_o, 0);
        do_cycle();
        chk("t6_flush_full", full_o, 0);
        chk("t6_flush_issue_valid", issue_instr_valid_o, 0);
        chk("t6_flush_commit_valid", commit_valid_o, 0);
        chk("t6_flush_issue_zero", issue_instr_o == '0, 1);
        chk("t6_flush_commit_zero", commit_instr_o == '0, 1);
        d_rs1 = 5'd1; d_rs2 = 5'd2;
        apply_inputs();
        #1;
        chk("t6_flush_rs1_busy", rs1_busy_o, 0);
        chk("t6_flush_rs2_busy", rs2_busy_o, 0);
        realign();
        for (int i = 0; i < 3; i++) begin
            d_push = 1; d_rd = 5'(i + 1); d_issue = 1;
            do_cycle();
        end
        d_wb = 1; d_tid = 0; d_wdata = 64'h66;
        do_cycle();
        d_rst = 1;
        do_cycle();
        chk("t6_rst_full", full_o, 0);
        chk("t6_rst_issue_valid", issue_instr_valid_o, 0);
        chk("t6_rst_commit_valid", commit_valid_o, 0);
        chk("t6_rst_issue_zero", issue_instr_o == '0, 1);
        chk("t6_rst_commit_zero", commit_instr_o == '0, 1);
        d_rs1 = 5'd1;
        apply_inputs();
        #1;
        chk("t6_rst_rs1_busy", rs1_busy_o, 0);
        realign();

        // Random traffic against the queue model
        do_flush();
        for (int c = 0; c < 400; c++) begin
            d_push   = ($urandom_range(0, 3) != 0);
            d_rd     = 5'($urandom_range(0, 7));
            d_issue  = $urandom_range(0, 1);
            d_commit = ($urandom_range(0, 3) != 0);
            d_flush  = ($urandom_range(0, 59) == 0);
            d_rs1    = 5'($urandom_range(0, 9));
            d_rs2    = 5'($urandom_range(0, 9));
            if ($urandom_range(0, 2) != 0) begin
                k = first_unwb();
                if (k >= 0) begin
                    j = $urandom_range(k, m_issued - 1);
                    if (!m_q[j].wb) k = j;
                    d_wb    = 1;
                    d_tid   = m_q[k].tid;
                    d_wdata = {$urandom, $urandom};
                    d_exv   = ($urandom_range(0, 7) == 0);
                    d_cause = 64'($urandom_range(0, 15));
                end
            end else if ($urandom_range(0, 4) == 0) begin
                d_tid = 5'($urandom_range(0, 31));
                d_wb  = 1;
                foreach (m_q[i]) if (m_q[i].tid == d_tid) d_wb = 0;
                d_wdata = 64'hF00D;
            end
            do_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
